// File: rtl/spatz_vlsu_mp.sv
// Multi-port strided vector load/store unit: one instruction at a time, 32-bit elements round-robin over N memory ports.
// Latency: loads commit a VRF word once every active lane FIFO holds data; stores take one VRF read plus per-lane issue per word.
// Backpressure: per-port load credits bound outstanding reads; mem/VRF valids hold until the handshake, never depending on ready.
// Ports: req_* (instruction in), rsp_* (completion pulse), vrf_w*/vrf_r* (VRF write/read), mem_* (per-port memory requests/responses).
module spatz_vlsu_mp #(
    parameter int NR_MEM_PORTS         = 2,
    parameter int NR_OUTSTANDING_LOADS = 4,
    parameter int VRF_AW               = 8,
    parameter int VL_W                 = 16,
    parameter int ID_W                 = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_store_i,
    input  logic [ID_W-1:0]           req_id_i,
    input  logic [31:0]               req_base_i,
    input  logic [31:0]               req_stride_i,
    input  logic [VL_W-1:0]           req_vl_i,
    input  logic [VRF_AW-1:0]         req_vd_i,
    output logic                      rsp_valid_o,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [VRF_AW-1:0]         vrf_waddr_o,
    output logic [32*NR_MEM_PORTS-1:0] vrf_wdata_o,
    output logic                      vrf_we_o,
    output logic [4*NR_MEM_PORTS-1:0] vrf_wbe_o,
    input  logic                      vrf_wvalid_i,
    output logic [VRF_AW-1:0]         vrf_raddr_o,
    output logic                      vrf_re_o,
    input  logic [32*NR_MEM_PORTS-1:0] vrf_rdata_i,
    input  logic                      vrf_rvalid_i,
    output logic [NR_MEM_PORTS-1:0]   mem_valid_o,
    input  logic [NR_MEM_PORTS-1:0]   mem_ready_i,
    output logic [32*NR_MEM_PORTS-1:0] mem_addr_o,
    output logic [NR_MEM_PORTS-1:0]   mem_we_o,
    output logic [32*NR_MEM_PORTS-1:0] mem_wdata_o,
    input  logic [NR_MEM_PORTS-1:0]   mem_rvalid_i,
    input  logic [32*NR_MEM_PORTS-1:0] mem_rdata_i
);
    localparam int N  = NR_MEM_PORTS;
    localparam int L  = NR_OUTSTANDING_LOADS;
    localparam int CW = $clog2(L + 1);
    localparam int PW = (L > 1) ? $clog2(L) : 1;
    localparam int EW = VL_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ST_READ, S_ST_WRITE, S_DONE} state_e;
    state_e r_state, w_state_nxt;

    logic [ID_W-1:0]   r_id;
    logic [31:0]       r_stride;
    logic [VL_W-1:0]   r_vl;
    logic [VRF_AW-1:0] r_vd, r_word;
    logic [EW-1:0]     r_elem;            // element index of lane 0 in the current word
    logic [31:0]       r_addr      [N];   // next address per port; shared by load issue and store lanes
    logic [EW-1:0]     r_issue_idx [N];   // next element index a load port will request
    logic [CW-1:0]     r_credit    [N];
    logic [31:0]       r_fifo      [N][L];
    logic [PW-1:0]     r_wptr      [N];
    logic [PW-1:0]     r_rptr      [N];
    logic [CW-1:0]     r_cnt       [N];
    logic [N-1:0]      r_st_done;         // store lanes already accepted for the current word
    logic [32*N-1:0]   r_stbuf;

    logic [N-1:0] w_lane_act, w_mem_vld, w_mem_hs, w_push, w_pop, w_fifo_full, w_fifo_ne;
    logic         w_last_word, w_commit_rdy, w_commit, w_st_all;

    always_comb begin
        w_lane_act  = '0;
        w_fifo_ne   = '0;
        w_fifo_full = '0;
        w_push      = '0;
        w_mem_vld   = '0;
        w_last_word = (r_elem + EW'(N)) >= {1'b0, r_vl};
        for (int p = 0; p < N; p++) begin
            w_lane_act[p]  = (r_elem + EW'(p)) < {1'b0, r_vl};
            w_fifo_ne[p]   = (r_cnt[p] != '0);
            w_fifo_full[p] = (r_cnt[p] == CW'(L));
            w_push[p]      = (r_state == S_LOAD) && mem_rvalid_i[p];
            if (r_state == S_LOAD)
                w_mem_vld[p] = (r_issue_idx[p] < {1'b0, r_vl}) && (r_credit[p] != '0);
            else if (r_state == S_ST_WRITE)
                w_mem_vld[p] = w_lane_act[p] && !r_st_done[p];
        end
        w_mem_hs     = w_mem_vld & mem_ready_i;
        w_commit_rdy = (r_state == S_LOAD) && (&(~w_lane_act | w_fifo_ne));
        w_commit     = w_commit_rdy && vrf_wvalid_i;
        w_pop        = {N{w_commit}} & w_lane_act;
        // A lane counts as done if accepted earlier in this word or in this cycle.
        w_st_all     = (r_state == S_ST_WRITE) && (&(~w_lane_act | r_st_done | w_mem_hs));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (req_vl_i == '0)   w_state_nxt = S_DONE;
                    else if (req_store_i) w_state_nxt = S_ST_READ;
                    else                  w_state_nxt = S_LOAD;
                end
            end
            S_LOAD:     if (w_commit && w_last_word) w_state_nxt = S_DONE;
            S_ST_READ:  if (vrf_rvalid_i) w_state_nxt = S_ST_WRITE;
            S_ST_WRITE: if (w_st_all) w_state_nxt = w_last_word ? S_DONE : S_ST_READ;
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (r_state == S_IDLE);
        rsp_valid_o = (r_state == S_DONE);
        rsp_id_o    = (r_state == S_DONE) ? r_id : '0;
        vrf_we_o    = w_commit_rdy;
        vrf_waddr_o = (r_state == S_LOAD) ? (r_vd + r_word) : '0;
        vrf_re_o    = (r_state == S_ST_READ);
        vrf_raddr_o = (r_state == S_ST_READ) ? (r_vd + r_word) : '0;
        vrf_wdata_o = '0;
        vrf_wbe_o   = '0;
        mem_valid_o = w_mem_vld;
        mem_addr_o  = '0;
        mem_we_o    = '0;
        mem_wdata_o = '0;
        for (int p = 0; p < N; p++) begin
            if ((r_state == S_LOAD) && w_lane_act[p]) begin
                vrf_wdata_o[32*p +: 32] = r_fifo[p][r_rptr[p]];
                vrf_wbe_o[4*p +: 4]     = 4'hF;
            end
            if (w_mem_vld[p]) mem_addr_o[32*p +: 32] = r_addr[p];
            if (w_mem_vld[p] && (r_state == S_ST_WRITE)) begin
                mem_we_o[p]             = 1'b1;
                mem_wdata_o[32*p +: 32] = r_stbuf[32*p +: 32];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_id      <= '0;
            r_stride  <= '0;
            r_vl      <= '0;
            r_vd      <= '0;
            r_word    <= '0;
            r_elem    <= '0;
            r_st_done <= '0;
            r_stbuf   <= '0;
            for (int p = 0; p < N; p++) begin
                r_addr[p]      <= '0;
                r_issue_idx[p] <= '0;
                r_credit[p]    <= CW'(L);
                r_wptr[p]      <= '0;
                r_rptr[p]      <= '0;
                r_cnt[p]       <= '0;
                for (int e = 0; e < L; e++) r_fifo[p][e] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && req_valid_i) begin
                r_id      <= req_id_i;
                r_stride  <= req_stride_i;
                r_vl      <= req_vl_i;
                r_vd      <= req_vd_i;
                r_word    <= '0;
                r_elem    <= '0;
                r_st_done <= '0;
                for (int p = 0; p < N; p++) begin
                    r_addr[p]      <= req_base_i + 32'(p) * req_stride_i;
                    r_issue_idx[p] <= EW'(p);
                end
            end
            for (int p = 0; p < N; p++) begin
                if (w_mem_hs[p]) begin
                    r_addr[p] <= r_addr[p] + r_stride * 32'(N);
                    if (r_state == S_LOAD) r_issue_idx[p] <= r_issue_idx[p] + EW'(N);
                end
                // Issue uses the registered credit, so a same-cycle return is visible next cycle.
                case ({w_mem_hs[p] && (r_state == S_LOAD), w_pop[p]})
                    2'b10:   r_credit[p] <= r_credit[p] - CW'(1);
                    2'b01:   r_credit[p] <= r_credit[p] + CW'(1);
                    default: r_credit[p] <= r_credit[p];
                endcase
                if (w_push[p]) begin
                    r_fifo[p][r_wptr[p]] <= mem_rdata_i[32*p +: 32];
                    r_wptr[p] <= (r_wptr[p] == PW'(L-1)) ? '0 : r_wptr[p] + PW'(1);
                end
                if (w_pop[p]) r_rptr[p] <= (r_rptr[p] == PW'(L-1)) ? '0 : r_rptr[p] + PW'(1);
                r_cnt[p] <= r_cnt[p] + CW'(w_push[p]) - CW'(w_pop[p]);
            end
            if ((r_state == S_ST_READ) && vrf_rvalid_i) r_stbuf <= vrf_rdata_i;
            if (r_state == S_ST_WRITE) r_st_done <= w_st_all ? '0 : (r_st_done | w_mem_hs);
            if (w_commit || w_st_all) begin
                r_elem <= r_elem + EW'(N);
                r_word <= r_word + VRF_AW'(1);
            end
        end
    end

    // Credits cap outstanding loads at the FIFO depth, so a push into a full FIFO means a broken invariant.
    assert property (@(posedge clk_i) disable iff (!rst_ni) (w_push & w_fifo_full) == '0);

endmodule

// File: tb/tb_spatz_vlsu_mp.sv
module tb_spatz_vlsu_mp;
    localparam int N = 2, L = 4, AW = 8, VW = 16, IW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic req_valid, req_ready, req_store;
    logic [IW-1:0] req_id;
    logic [31:0] req_base, req_stride;
    logic [VW-1:0] req_vl;
    logic [AW-1:0] req_vd;
    logic rsp_valid;
    logic [IW-1:0] rsp_id;
    logic [AW-1:0] vrf_waddr, vrf_raddr;
    logic [32*N-1:0] vrf_wdata, vrf_rdata;
    logic vrf_we, vrf_wvalid, vrf_re, vrf_rvalid;
    logic [4*N-1:0] vrf_wbe;
    logic [N-1:0] mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [32*N-1:0] mem_addr, mem_wdata, mem_rdata;

    spatz_vlsu_mp #(.NR_MEM_PORTS(N), .NR_OUTSTANDING_LOADS(L), .VRF_AW(AW), .VL_W(VW), .ID_W(IW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_store_i(req_store), .req_id_i(req_id),
        .req_base_i(req_base), .req_stride_i(req_stride), .req_vl_i(req_vl), .req_vd_i(req_vd),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id),
        .vrf_waddr_o(vrf_waddr), .vrf_wdata_o(vrf_wdata), .vrf_we_o(vrf_we), .vrf_wbe_o(vrf_wbe),
        .vrf_wvalid_i(vrf_wvalid), .vrf_raddr_o(vrf_raddr), .vrf_re_o(vrf_re),
        .vrf_rdata_i(vrf_rdata), .vrf_rvalid_i(vrf_rvalid),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
        .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } mreq_t;
    typedef struct { logic [AW-1:0] addr; logic [63:0] data; logic [7:0] wbe; } vw_t;

    mreq_t        exp_mem [N][$];
    vw_t          exp_vrf [$];
    logic [IW-1:0] exp_rsp [$];
    logic [31:0]  rq [N][$];        // load addresses awaiting a memory response
    logic [63:0]  vrf_mem [256];

    int compared = 0, errors = 0;
    int iss_cnt [N];
    int rdy_prob [N];
    int rel [N];
    int rv_prob, wv_prob, rd_prob;
    logic [N-1:0] prev_vld;
    logic [31:0] prev_addr [N], prev_wdata [N];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        compared++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        compared++;
        errors++;
        $display("FAIL %s: bound expired without the awaited DUT event", nm);
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    endtask

    // Reference model: element i -> port i%N, VRF word vd+i/N, address base+i*stride.
    task automatic push_expect(input logic st, input logic [IW-1:0] id, input logic [31:0] base,
                               input logic [31:0] stride, input int vl, input int vd);
        mreq_t m;
        vw_t v;
        for (int i = 0; i < vl; i++) begin
            int p;
            logic [63:0] w;
            p = i % N;
            w = vrf_mem[8'(vd + i / N)];
            m.addr  = base + 32'(i) * stride;
            m.we    = st;
            m.wdata = st ? w[32*p +: 32] : 32'h0;
            exp_mem[p].push_back(m);
        end
        if (!st) begin
            for (int wd = 0; wd < (vl + N - 1) / N; wd++) begin
                v.addr = AW'(vd + wd);
                v.data = '0;
                v.wbe  = '0;
                for (int p = 0; p < N; p++) begin
                    if (wd * N + p < vl) begin
                        v.data[32*p +: 32] = base + 32'(wd * N + p) * stride;
                        v.wbe[4*p +: 4]    = 4'hF;
                    end
                end
                exp_vrf.push_back(v);
            end
        end
        exp_rsp.push_back(id);
    endtask

    task automatic issue(input logic st, input logic [IW-1:0] id, input logic [31:0] base,
                         input logic [31:0] stride, input int vl, input int vd);
        int t;
        logic ok;
        push_expect(st, id, base, stride, vl, vd);
        @(posedge clk); #1;
        req_valid = 1'b1; req_store = st; req_id = id; req_base = base;
        req_stride = stride; req_vl = VW'(vl); req_vd = AW'(vd);
        t = 0;
        do begin
            @(negedge clk); ok = req_ready;
            @(posedge clk); t++;
        end while (!ok && t < 1000);
        #1 req_valid = 1'b0;
        if (!ok) begin timeout_fail("req_accept"); finish_run(); end
    endtask

    function automatic int pending();
        return exp_rsp.size() + exp_vrf.size() + exp_mem[0].size() + exp_mem[1].size();
    endfunction

    task automatic wait_done(input int bound);
        int t;
        t = 0;
        while (pending() != 0 && t < bound) begin @(negedge clk); t++; end
        if (pending() != 0) begin timeout_fail("completion"); finish_run(); end
    endtask

    task automatic chk_reset();
        chk("rst_req_ready", 96'(req_ready), 96'(1));
        chk("rst_rsp", 96'({rsp_valid, rsp_id}), 96'(0));
        chk("rst_vrf_ctl", 96'({vrf_we, vrf_re, vrf_waddr, vrf_raddr, vrf_wbe}), 96'(0));
        chk("rst_vrf_wdata", 96'(vrf_wdata), 96'(0));
        chk("rst_mem_ctl", 96'({mem_valid, mem_we}), 96'(0));
        chk("rst_mem_addr", 96'(mem_addr), 96'(0));
        chk("rst_mem_wdata", 96'(mem_wdata), 96'(0));
    endtask

    task automatic set_knobs(input int r0, input int r1, input int rv, input int wv, input int rd);
        rdy_prob[0] = r0; rdy_prob[1] = r1; rv_prob = rv; wv_prob = wv; rd_prob = rd;
    endtask

    initial begin
        int b;
        int t;
        logic [31:0] stride;
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_id = '0; req_base = '0;
        req_stride = '0; req_vl = '0; req_vd = '0; vrf_wvalid = 1'b0; vrf_rvalid = 1'b0;
        vrf_rdata = '0; mem_ready = '0; mem_rvalid = '0; mem_rdata = '0; prev_vld = '0;
        for (int p = 0; p < N; p++) begin iss_cnt[p] = 0; rel[p] = 1 << 30; end
        set_knobs(100, 100, 100, 100, 100);
        for (int i = 0; i < 256; i++) vrf_mem[i] = {$urandom, $urandom};

        fork
            // Environment: memory ports, load responses and the VRF.
            forever begin
                @(posedge clk); #1;
                for (int p = 0; p < N; p++) begin
                    mem_ready[p]  = ($urandom_range(99) < rdy_prob[p]);
                    mem_rvalid[p] = 1'b0;
                    mem_rdata[32*p +: 32] = $urandom;
                    if (rq[p].size() > 0 && rel[p] > 0 && $urandom_range(99) < rv_prob) begin
                        mem_rvalid[p] = 1'b1;
                        mem_rdata[32*p +: 32] = rq[p].pop_front();
                        rel[p]--;
                    end
                end
                vrf_wvalid = ($urandom_range(99) < wv_prob);
                vrf_rvalid = vrf_re && ($urandom_range(99) < rd_prob);
                vrf_rdata  = vrf_rvalid ? vrf_mem[vrf_raddr] : {$urandom, $urandom};
            end
            // Monitor: compares every handshake against the scoreboard queues.
            forever begin
                @(negedge clk);
                if (!rst_n) prev_vld = '0;
                else begin
                    for (int p = 0; p < N; p++) begin
                        if (prev_vld[p])
                            chk("mem_hold", 96'({mem_valid[p], mem_addr[32*p +: 32], mem_wdata[32*p +: 32]}),
                                96'({1'b1, prev_addr[p], prev_wdata[p]}));
                        if (mem_valid[p] && mem_ready[p]) begin
                            iss_cnt[p]++;
                            if (exp_mem[p].size() == 0) timeout_fail("mem_unexpected_request");
                            else begin
                                mreq_t m;
                                m = exp_mem[p].pop_front();
                                chk("mem_req", 96'({mem_addr[32*p +: 32], mem_we[p]}), 96'({m.addr, m.we}));
                                if (m.we) chk("mem_wdata", 96'(mem_wdata[32*p +: 32]), 96'(m.wdata));
                            end
                            if (!mem_we[p]) rq[p].push_back(mem_addr[32*p +: 32]);
                        end
                        prev_vld[p]   = mem_valid[p] & ~mem_ready[p];
                        prev_addr[p]  = mem_addr[32*p +: 32];
                        prev_wdata[p] = mem_wdata[32*p +: 32];
                    end
                    if (vrf_we && vrf_wvalid) begin
                        if (exp_vrf.size() == 0) timeout_fail("vrf_unexpected_write");
                        else begin
                            vw_t v;
                            v = exp_vrf.pop_front();
                            chk("vrf_write", 96'({vrf_waddr, vrf_wbe, vrf_wdata}), 96'({v.addr, v.wbe, v.data}));
                        end
                    end
                    if (rsp_valid) begin
                        if (exp_rsp.size() == 0) timeout_fail("rsp_unexpected");
                        else chk("rsp_id", 96'(rsp_id), 96'(exp_rsp.pop_front()));
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk_reset();
        #2 rst_n = 1'b1;

        // Unit-stride load with a partial last word.
        issue(1'b0, 5'd1, 32'h1000, 32'd4, 5, 3);
        wait_done(500);

        // vl = 0: immediate one-cycle response, no traffic.
        issue(1'b0, 5'd2, 32'h5000, 32'd4, 0, 7);
        @(negedge clk);
        chk("vl0_rsp", 96'(rsp_valid), 96'(1));
        chk("vl0_busy", 96'(req_ready), 96'(0));
        @(negedge clk);
        chk("vl0_pulse", 96'(rsp_valid), 96'(0));
        wait_done(100);

        // Strided store from two known VRF words.
        vrf_mem[8'h40] = {32'hBBBB_0001, 32'hAAAA_0000};
        vrf_mem[8'h41] = {32'hDDDD_0003, 32'hCCCC_0002};
        issue(1'b1, 5'd3, 32'h2000, 32'h20, 4, 8'h40);
        wait_done(500);

        // Credit limit: withhold port-0 responses, then release exactly one.
        rel[0] = 0;
        b = iss_cnt[0];
        issue(1'b0, 5'd4, 32'h3000, 32'd4, 16, 8'h10);
        repeat (30) @(negedge clk);
        chk("credit_stall_cnt", 96'(iss_cnt[0] - b), 96'(4));
        chk("credit_stall_vld", 96'(mem_valid[0]), 96'(0));
        rel[0] = 1;
        repeat (10) @(negedge clk);
        chk("credit_return_cnt", 96'(iss_cnt[0] - b), 96'(5));
        chk("credit_return_vld", 96'(mem_valid[0]), 96'(0));
        rel[0] = 1 << 30;
        wait_done(1000);

        // Randomised mix with ready toggling and VRF stalls.
        set_knobs(80, 50, 70, 60, 70);
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(4))
                0: stride = 32'd4;
                1: stride = 32'd0;
                2: stride = 32'hFFFF_FFFC;
                3: stride = 32'h20;
                default: stride = $urandom;
            endcase
            issue(1'($urandom_range(1)), IW'(k + 11), $urandom, stride, $urandom_range(11), $urandom_range(255));
            wait_done(3000);
        end

        // Reset with three loads outstanding, late data in IDLE, then a clean load.
        set_knobs(100, 100, 100, 100, 100);
        rel[0] = 0; rel[1] = 0;
        b = iss_cnt[0] + iss_cnt[1];
        issue(1'b0, 5'd9, 32'h7000, 32'd4, 3, 8'h20);
        t = 0;
        while ((iss_cnt[0] + iss_cnt[1] - b) < 3 && t < 200) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        chk("outstanding_before_reset", 96'(iss_cnt[0] + iss_cnt[1] - b), 96'(3));
        @(posedge clk); #1 rst_n = 1'b0;
        exp_vrf.delete(); exp_rsp.delete();
        for (int p = 0; p < N; p++) exp_mem[p].delete();
        @(negedge clk);
        chk_reset();
        #2 rst_n = 1'b1;
        rel[0] = 1 << 30; rel[1] = 1 << 30;
        repeat (10) @(negedge clk);
        issue(1'b0, 5'd10, 32'h8000, 32'hC, 7, 8'h30);
        wait_done(1000);

        repeat (5) @(negedge clk);
        chk("queues_drained", 96'(pending()), 96'(0));
        finish_run();
    end
endmodule

// File: doc/spatz_vlsu_mp.md
Name: spatz_vlsu_mp

Overview:
Multi-port vector load/store unit for Spatz. It executes one strided vector load or store at a time, with 32-bit elements spread round-robin across NR_MEM_PORTS independent memory ports. Loads are reassembled into full VRF words; stores are sliced from VRF words. It sits between the Spatz controller, the VRF and the X-interface memory ports. It replaces the single-port VLSU with per-port credit tracking and full stride support.

Parameters:
NR_MEM_PORTS, 2, number of memory ports; also the number of 32-bit lanes per VRF word.
NR_OUTSTANDING_LOADS, 4, per-port load credits; also the depth of each per-port result FIFO.
VRF_AW, 8, VRF word-address width.
VL_W, 16, width of the vector-length field.
ID_W, 5, instruction ID width.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  new LSU instruction
req_ready_o  out  1  unit can accept an instruction
req_store_i  in  1  1 = store, 0 = load
req_id_i  in  ID_W  instruction ID
req_base_i  in  32  base byte address
req_stride_i  in  32  byte stride (unit stride = 4)
req_vl_i  in  VL_W  element count
req_vd_i  in  VRF_AW  first VRF word address
rsp_valid_o  out  1  instruction-complete pulse
rsp_id_o  out  ID_W  ID of the completed instruction
vrf_waddr_o  out  VRF_AW  VRF write address
vrf_wdata_o  out  32*NR_MEM_PORTS  VRF write data
vrf_we_o  out  1  VRF write request
vrf_wbe_o  out  4*NR_MEM_PORTS  VRF byte enables
vrf_wvalid_i  in  1  VRF write accepted
vrf_raddr_o  out  VRF_AW  VRF read address
vrf_re_o  out  1  VRF read request
vrf_rdata_i  in  32*NR_MEM_PORTS  VRF read data
vrf_rvalid_i  in  1  VRF read data valid
mem_valid_o  out  NR_MEM_PORTS  per-port request valid
mem_ready_i  in  NR_MEM_PORTS  per-port request ready
mem_addr_o  out  32*NR_MEM_PORTS  per-port byte address
mem_we_o  out  NR_MEM_PORTS  per-port write enable
mem_wdata_o  out  32*NR_MEM_PORTS  per-port write data
mem_rvalid_i  in  NR_MEM_PORTS  per-port load-data valid (in order per port)
mem_rdata_i  in  32*NR_MEM_PORTS  per-port load data

Behaviour:
- Reset: FSM in IDLE, all counters and FIFOs cleared, all credits = NR_OUTSTANDING_LOADS. Every output is 0 except req_ready_o = 1.
- Element mapping: element i goes to port/lane p = i mod N and VRF word vd + i/N. Address = base + i*stride, mod 2^32.
- FSM states: IDLE, LOAD, ST_READ, ST_WRITE, DONE.
  - req_ready_o = (state == IDLE).
  - On accept, latch all req fields. vl = 0 goes to DONE. Otherwise a load goes to LOAD and a store goes to ST_READ.
- LOAD:
  - Port p asserts mem_valid_o[p] while it has unissued elements and credit[p] > 0.
  - On valid & ready: credit decrements and the port element counter advances.
  - mem_rvalid_i[p] pushes mem_rdata_i into FIFO p. A push while the FIFO is full is an assertion failure; the credit scheme makes it impossible.
  - Word commit: vrf_we_o = 1 when every active lane of the current word has a non-empty FIFO. Active lanes are those whose element index < vl.
  - vrf_wbe_o sets 4'hF for active lanes and 0 for the rest. vrf_wdata_o is the FIFO heads; inactive lanes are 0.
  - On vrf_wvalid_i: pop the active lanes, return one credit each (a same-cycle issue sees the old credit), advance the word.
  - After the last word commits, go to DONE.
- ST_READ: vrf_re_o = 1 with vrf_raddr_o = current word. On vrf_rvalid_i, latch the data into the store buffer and go to ST_WRITE.
- ST_WRITE:
  - Each active lane drives mem_we_o = 1, its address and its buffer lane. Lanes issue independently.
  - Each lane's valid drops after its handshake.
  - When all active lanes are accepted: go to ST_READ for the next word, or to DONE after the last word.
  - Stores are fire-and-forget; mem_rvalid_i is ignored outside LOAD.
- DONE: rsp_valid_o = 1 for exactly one cycle with rsp_id_o = latched ID, then IDLE. Completion means every load is written to the VRF, or every store is accepted by memory.
- mem_rvalid_i outside LOAD is dropped.
- Reset mid-operation aborts the instruction with no response. Late load data then arrives in IDLE and is dropped.
- mem_valid_o is held stable with constant address and data until ready (AXI-like). No combinational path exists from mem_ready_i to mem_valid_o.

Test Plan:
1. Load, N=2, base=0x1000, stride=4, vl=5, vd=3, memory returns addr as data -> ports issue 0x1000/0x1008/0x1010 and 0x1004/0x100C. VRF writes: word 3 = {0x1004,0x1000}, word 4 = {0x100C,0x1008}, word 5 = {0,0x1010} with wbe=8'h0F. Then one rsp pulse.
2. Load with responses withheld on port 0 -> exactly 4 port-0 requests, then mem_valid_o[0] stays low. Releasing one response plus its VRF commit restores one credit.
3. Store, stride=0x20, vl=4, base=0x2000, VRF words {B,A},{D,C} -> writes A@0x2000, B@0x2020, C@0x2040, D@0x2060 with mem_we_o=1. rsp after the last accept.
4. vl=0 load -> no mem or VRF traffic; rsp_valid_o one cycle after accept; req_ready_o low for that cycle.
5. mem_ready_i toggling randomly on one port, plus vrf_wvalid_i stalls -> address and data stay stable while valid is high, and data order is preserved.
6. rst_ni asserted mid-load with 3 outstanding requests -> all outputs return to reset values with no rsp. A following load completes correctly.
